// File: rtl/pmem_types_pkg.sv
// rtl/pmem_types_pkg.sv - shared widths, types and FSM states for the line buffer initiator
package pmem_types_pkg;

  localparam int ADDR_WIDTH     = 16;
  localparam int WORD_WIDTH     = 16;
  localparam int LINE_WIDTH     = 256;
  localparam int WORDS_PER_LINE = LINE_WIDTH / WORD_WIDTH;
  localparam int OFFSET_BITS    = $clog2(WORDS_PER_LINE);
  localparam int TAG_WIDTH      = ADDR_WIDTH - OFFSET_BITS;

  typedef logic [LINE_WIDTH-1:0]  line_t;
  typedef logic [WORD_WIDTH-1:0]  word_t;
  typedef logic [TAG_WIDTH-1:0]   tag_t;
  typedef logic [OFFSET_BITS-1:0] offset_t;
  typedef logic [ADDR_WIDTH-1:0]  addr_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FILL,
    DONE
  } initiator_state_e;

  // Line-aligned pmem address for a tag.
  function automatic addr_t line_address(input tag_t tag);
    return {tag, {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/line_word_merge.sv
// rtl/line_word_merge.sv - combinational word select and byte-enable merge into a cache line
//  line_i       in   256  current buffered line
//  offset       in   4    word index within the line
//  wdata        in   16   CPU write word
//  byte_enable  in   2    per-byte write enable
//  merged_line  out  256  line_i with the enabled bytes of wdata written at offset
//  rd_word      out  16   word at offset from line_i
module line_word_merge
  import pmem_types_pkg::*;
(
  input  line_t      line_i,
  input  offset_t    offset,
  input  word_t      wdata,
  input  logic [1:0] byte_enable,
  output line_t      merged_line,
  output word_t      rd_word
);

  // Unrolled compare per word keeps every slice constant-indexed.
  always_comb begin
    rd_word     = '0;
    merged_line = line_i;
    for (int k = 0; k < WORDS_PER_LINE; k++) begin
      if (offset == offset_t'(k)) begin
        rd_word = line_i[k*WORD_WIDTH +: WORD_WIDTH];
        if (byte_enable[0]) merged_line[k*WORD_WIDTH +: 8]     = wdata[7:0];
        if (byte_enable[1]) merged_line[k*WORD_WIDTH + 8 +: 8] = wdata[15:8];
      end
    end
  end

endmodule

// File: rtl/line_buffer_initiator.sv
// rtl/line_buffer_initiator.sv - 16-bit CPU word port onto 256-bit pmem lines via one write-back line buffer
//  clk, rst                     clock, asynchronous active-high reset
//  mem_read/mem_write           CPU request, held until mem_resp
//  mem_address/mem_wdata        word address {tag, offset}, write word
//  mem_byte_enable              per-byte write enable
//  mem_resp/mem_rdata           one-cycle completion pulse, read word
//  pmem_read/pmem_write         line request towards memory, held until pmem_resp
//  pmem_address/pmem_wdata      line address {tag, 4'b0}, line being written back
//  pmem_resp/pmem_rdata         memory completion pulse, fill line
module line_buffer_initiator
  import pmem_types_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  input  logic [1:0]  mem_byte_enable,
  output logic        mem_resp,
  output logic [15:0] mem_rdata,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [15:0] pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic        pmem_resp,
  input  logic [255:0] pmem_rdata
);

  initiator_state_e state_q, state_d;
  logic  valid_q, valid_d;
  logic  dirty_q, dirty_d;
  tag_t  tag_q, tag_d;
  line_t line_q, line_d;
  logic  mem_resp_q, mem_resp_d;
  word_t mem_rdata_q, mem_rdata_d;
  logic  pmem_read_q, pmem_read_d;
  logic  pmem_write_q, pmem_write_d;
  addr_t pmem_address_q, pmem_address_d;
  line_t pmem_wdata_q, pmem_wdata_d;

  tag_t  req_tag;
  logic  req_valid;
  logic  hit;
  line_t merged_line;
  word_t rd_word;

  assign req_tag   = mem_address[ADDR_WIDTH-1:OFFSET_BITS];
  assign req_valid = mem_read | mem_write;
  assign hit       = valid_q & (tag_q == req_tag);

  line_word_merge u_merge (
    .line_i      (line_q),
    .offset      (mem_address[OFFSET_BITS-1:0]),
    .wdata       (mem_wdata),
    .byte_enable (mem_byte_enable),
    .merged_line (merged_line),
    .rd_word     (rd_word)
  );

  always_comb begin
    state_d        = state_q;
    valid_d        = valid_q;
    dirty_d        = dirty_q;
    tag_d          = tag_q;
    line_d         = line_q;
    mem_resp_d     = 1'b0;
    mem_rdata_d    = mem_rdata_q;
    pmem_read_d    = pmem_read_q;
    pmem_write_d   = pmem_write_q;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (hit) begin
            if (mem_write) begin
              // A write with no byte enables still marks the line dirty.
              line_d  = merged_line;
              dirty_d = 1'b1;
            end else begin
              mem_rdata_d = rd_word;
            end
            mem_resp_d = 1'b1;
            state_d    = DONE;
          end else if (dirty_q) begin
            pmem_write_d   = 1'b1;
            pmem_address_d = line_address(tag_q);
            pmem_wdata_d   = line_q;
            state_d        = WRITEBACK;
          end else begin
            pmem_read_d    = 1'b1;
            pmem_address_d = line_address(req_tag);
            state_d        = FILL;
          end
        end
      end

      WRITEBACK: begin
        if (pmem_resp) begin
          dirty_d        = 1'b0;
          pmem_write_d   = 1'b0;
          pmem_read_d    = 1'b1;
          pmem_address_d = line_address(req_tag);
          state_d        = FILL;
        end
      end

      FILL: begin
        if (pmem_resp) begin
          // The tag comes from the live request; IDLE then completes it as a hit.
          line_d      = pmem_rdata;
          tag_d       = req_tag;
          valid_d     = 1'b1;
          dirty_d     = 1'b0;
          pmem_read_d = 1'b0;
          state_d     = IDLE;
        end
      end

      DONE: begin
        // The CPU still holds the finished request this cycle; skip it.
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      valid_q        <= 1'b0;
      dirty_q        <= 1'b0;
      tag_q          <= '0;
      line_q         <= '0;
      mem_resp_q     <= 1'b0;
      mem_rdata_q    <= '0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      valid_q        <= valid_d;
      dirty_q        <= dirty_d;
      tag_q          <= tag_d;
      line_q         <= line_d;
      mem_resp_q     <= mem_resp_d;
      mem_rdata_q    <= mem_rdata_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
    end
  end

  assign mem_resp     = mem_resp_q;
  assign mem_rdata    = mem_rdata_q;
  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;

endmodule

// File: tb/tb_line_buffer_initiator.sv
// tb/tb_line_buffer_initiator.sv - self-checking bench for line_buffer_initiator
module tb_line_buffer_initiator;

  logic         clk;
  logic         rst;
  logic         mem_read;
  logic         mem_write;
  logic [15:0]  mem_address;
  logic [15:0]  mem_wdata;
  logic [1:0]   mem_byte_enable;
  logic         mem_resp;
  logic [15:0]  mem_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         pmem_resp;
  logic [255:0] pmem_rdata;

  line_buffer_initiator dut (
    .clk             (clk),
    .rst             (rst),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata),
    .pmem_resp       (pmem_resp),
    .pmem_rdata      (pmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_reads = 0;
  int n_writes = 0;
  int n_resp = 0;
  int n_req = 0;
  int n_both = 0;
  logic [15:0]  last_rd_addr;
  logic [15:0]  last_wr_addr;
  logic [255:0] last_wr_data;

  // Memory contents as seen by the pmem responder, and by the reference model.
  logic [255:0] pmem_store [logic [11:0]];
  logic [255:0] ref_mem    [logic [11:0]];

  // Reference model of the single buffered line.
  bit           m_valid = 0;
  bit           m_dirty = 0;
  logic [11:0]  m_tag = '0;
  logic [255:0] m_line = '0;
  bit           prev_b2b = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] init_word(input logic [11:0] tag, input int k);
    logic [31:0] t;
    if (tag == 12'h123 && k == 4) return 16'hBEEF;
    t = ({20'b0, tag} << 4) + 32'(k);
    t = t * 32'd40503;
    return t[15:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [255:0] init_line(input logic [11:0] tag);
    logic [255:0] l;
    for (int k = 0; k < 16; k++) l[k*16 +: 16] = init_word(tag, k);
    return l;
  endfunction

  // pmem responder: ~250 ns per transfer, abandons it if reset arrives.
  initial begin : responder
    logic         wr;
    logic [15:0]  a;
    logic [255:0] d;
    bit           aborted;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst && (pmem_read || pmem_write)) begin
        wr = pmem_write;
        a  = pmem_address;
        d  = pmem_wdata;
        if (wr) begin
          n_writes++;
          last_wr_addr = a;
          last_wr_data = d;
        end else begin
          n_reads++;
          last_rd_addr = a;
        end
        aborted = 0;
        for (int i = 0; i < 24; i++) begin
          @(negedge clk);
          if (rst) begin
            aborted = 1;
            break;
          end
        end
        if (!aborted) begin
          check("pmem_addr_stable", {240'b0, pmem_address}, {240'b0, a});
          if (wr) begin
            check("pmem_wdata_stable", pmem_wdata, d);
            pmem_store[a[15:4]] = d;
          end else begin
            pmem_rdata = pmem_store.exists(a[15:4]) ? pmem_store[a[15:4]] : init_line(a[15:4]);
          end
          pmem_resp = 1'b1;
          @(negedge clk);
          pmem_resp  = 1'b0;
          pmem_rdata = '0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mem_resp) n_resp++;
    if (pmem_read && pmem_write) n_both++;
  end

  // One CPU request, checked against the model. Called at a negedge.
  task automatic do_req(input bit is_wr, input logic [15:0] addr, input logic [15:0] wd,
                        input logic [1:0] be, input bit b2b,
                        output logic [15:0] rd, output int dr, output int dw);
    logic [11:0]  tag;
    int           off;
    bit           hit;
    int           e_r, e_w, cyc, r0, w0;
    logic [11:0]  wb_tag;
    logic [255:0] wb_line;
    logic [15:0]  e_rd;
    bit           got;
    tag = addr[15:4];
    off = int'(addr[3:0]);
    hit = m_valid && (m_tag == tag);
    e_r = hit ? 0 : 1;
    e_w = (!hit && m_dirty) ? 1 : 0;
    wb_tag  = m_tag;
    wb_line = m_line;
    if (!hit) begin
      if (m_dirty) ref_mem[m_tag] = m_line;
      m_line  = ref_mem.exists(tag) ? ref_mem[tag] : init_line(tag);
      m_tag   = tag;
      m_valid = 1;
      m_dirty = 0;
    end
    e_rd = m_line[off*16 +: 16];
    if (is_wr) begin
      if (be[0]) m_line[off*16 +: 8]     = wd[7:0];
      if (be[1]) m_line[off*16 + 8 +: 8] = wd[15:8];
      m_dirty = 1;
    end

    r0 = n_reads;
    w0 = n_writes;
    mem_read        = !is_wr;
    mem_write       = is_wr;
    mem_address     = addr;
    mem_wdata       = wd;
    mem_byte_enable = be;
    cyc = 0;
    got = 0;
    while (!got && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (mem_resp) got = 1;
    end
    rd = mem_rdata;
    dr = n_reads - r0;
    dw = n_writes - w0;
    check("resp_seen", 256'(got), 256'(1));
    if (got) n_req++;
    if (!is_wr) check("rdata", {240'b0, rd}, {240'b0, e_rd});
    check("pmem_reads", 256'(dr), 256'(e_r));
    check("pmem_writes", 256'(dw), 256'(e_w));
    if (e_w == 1 && dw == 1) begin
      check("wb_addr", {240'b0, last_wr_addr}, {240'b0, wb_tag, 4'b0});
      check("wb_data", last_wr_data, wb_line);
    end
    if (e_r == 1 && dr == 1) check("fill_addr", {240'b0, last_rd_addr}, {240'b0, tag, 4'b0});
    if (hit) check("hit_latency", 256'(cyc), prev_b2b ? 256'(2) : 256'(1));
    if (!b2b || !got) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      @(negedge clk);
    end
    prev_b2b = b2b && got;
  endtask

  task automatic do_reset(input bit check_outputs);
    #2;
    rst       = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    #1;
    if (check_outputs) begin
      check("rst_mem_resp", 256'(mem_resp), 256'(0));
      check("rst_mem_rdata", {240'b0, mem_rdata}, 256'(0));
      check("rst_pmem_read", 256'(pmem_read), 256'(0));
      check("rst_pmem_write", 256'(pmem_write), 256'(0));
      check("rst_pmem_address", {240'b0, pmem_address}, 256'(0));
    end
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    m_valid  = 0;
    m_dirty  = 0;
    prev_b2b = 0;
    @(negedge clk);
  endtask

  task automatic wait_for(input bit want_write, input string name);
    int c;
    c = 0;
    while (!(want_write ? pmem_write : pmem_read) && c < 20) begin
      @(negedge clk);
      c++;
    end
    check(name, 256'(want_write ? pmem_write : pmem_read), 256'(1));
  endtask

  typedef struct {
    bit          is_write;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp_rdata;
    int          exp_reads;
    int          exp_writes;
  } vec_t;

  vec_t vecs[8];

  initial begin : main
    logic [15:0] rd;
    int          dr, dw;
    logic [11:0] pool[4];
    pool[0] = 12'h123; pool[1] = 12'h456; pool[2] = 12'h999; pool[3] = 12'h7AB;

    vecs[0] = '{0, 16'h1234, 16'h0000, 2'b00, 16'hBEEF, 1, 0};
    vecs[1] = '{0, 16'h1235, 16'h0000, 2'b00, init_word(12'h123, 5), 0, 0};
    vecs[2] = '{1, 16'h1234, 16'hA55A, 2'b01, 16'h0000, 0, 0};
    vecs[3] = '{0, 16'h1234, 16'h0000, 2'b00, 16'hBE5A, 0, 0};
    vecs[4] = '{0, 16'h4560, 16'h0000, 2'b00, init_word(12'h456, 0), 1, 1};
    vecs[5] = '{1, 16'h4563, 16'hFFFF, 2'b00, 16'h0000, 0, 0};
    vecs[6] = '{0, 16'h4563, 16'h0000, 2'b00, init_word(12'h456, 3), 0, 0};
    vecs[7] = '{0, 16'h9990, 16'h0000, 2'b00, init_word(12'h999, 0), 1, 1};

    rst = 1'b1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_address = '0;
    mem_wdata = '0;
    mem_byte_enable = '0;
    repeat (3) @(negedge clk);
    check("reset_mem_resp", 256'(mem_resp), 256'(0));
    check("reset_pmem_read", 256'(pmem_read), 256'(0));
    check("reset_pmem_write", 256'(pmem_write), 256'(0));
    check("reset_pmem_address", {240'b0, pmem_address}, 256'(0));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      do_req(vecs[i].is_write, vecs[i].addr, vecs[i].wdata, vecs[i].be, 0, rd, dr, dw);
      if (!vecs[i].is_write) check($sformatf("vec%0d_rdata", i), {240'b0, rd}, {240'b0, vecs[i].exp_rdata});
      check($sformatf("vec%0d_reads", i), 256'(dr), 256'(vecs[i].exp_reads));
      check($sformatf("vec%0d_writes", i), 256'(dw), 256'(vecs[i].exp_writes));
      if (i == 4) begin
        check("wb_1230_addr", {240'b0, last_wr_addr}, {240'b0, 16'h1230});
        check("wb_1230_word4", {240'b0, last_wr_data[4*16 +: 16]}, {240'b0, 16'hBE5A});
        check("fill_4560_addr", {240'b0, last_rd_addr}, {240'b0, 16'h4560});
      end
    end

    // Back-to-back hits held straight across DONE.
    do_req(0, 16'h9991, 16'h0, 2'b00, 1, rd, dr, dw);
    do_req(1, 16'h9992, 16'h1357, 2'b11, 1, rd, dr, dw);
    do_req(0, 16'h9992, 16'h0, 2'b00, 1, rd, dr, dw);
    check("b2b_rdata", {240'b0, rd}, {240'b0, 16'h1357});
    do_req(0, 16'h9993, 16'h0, 2'b00, 0, rd, dr, dw);

    // Reset during WRITEBACK: the dirty line is lost.
    do_req(1, 16'h9991, 16'hCAFE, 2'b11, 0, rd, dr, dw);
    mem_read    = 1'b1;
    mem_address = 16'h4560;
    wait_for(1, "wb_started");
    repeat (5) @(negedge clk);
    do_reset(1);
    do_req(0, 16'h9991, 16'h0, 2'b00, 0, rd, dr, dw);
    check("lost_write_rdata", {240'b0, rd}, {240'b0, init_word(12'h999, 1)});

    // Reset during FILL, then re-fill a line that was written back earlier.
    mem_read    = 1'b1;
    mem_address = 16'hABC0;
    wait_for(0, "fill_started");
    repeat (5) @(negedge clk);
    do_reset(1);
    do_req(0, 16'h1234, 16'h0, 2'b00, 0, rd, dr, dw);
    check("refill_1234", {240'b0, rd}, {240'b0, 16'hBE5A});

    // Randomized traffic over a small tag pool.
    for (int i = 0; i < 40; i++) begin
      logic [15:0] a;
      a = {pool[$urandom_range(0, 3)], 4'($urandom_range(0, 15))};
      do_req(1'($urandom_range(0, 1)), a, 16'($urandom), 2'($urandom_range(0, 3)),
             $urandom_range(0, 3) == 0, rd, dr, dw);
    end
    do_req(0, 16'h1230, 16'h0, 2'b00, 0, rd, dr, dw);
    repeat (3) @(negedge clk);

    check("resp_count", 256'(n_resp), 256'(n_req));
    check("never_both_high", 256'(n_both), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
